// File: rtl/countdown_timer_sync.sv
// Button-driven mm:ss BCD countdown/stopwatch timer with an internal tick prescaler.
// Optional macro HOLD_REPEAT_EN adds auto-repeat on held ADD buttons while idle.
module countdown_timer_sync #(
  parameter int CLK_HZ     = 25175000,
  parameter int TICK_HZ    = 1,
  parameter int MIN_DIGITS = 2
) (
  input  logic                          MCLK,
  input  logic                          RESET,
  input  logic                          START_STOP_N,
  input  logic                          ADD_SEC_N,
  input  logic                          ADD_MIN_N,
  input  logic                          CLR_N,
  input  logic                          MODE_UP,
  output logic [4*(MIN_DIGITS+2)-1:0]   TIME_BCD,
  output logic                          RUNNING,
  output logic                          ALARM,
  output logic                          TICK
);

  localparam int ND   = MIN_DIGITS + 2;
  localparam int W    = 4 * ND;
  localparam int PDIV = CLK_HZ / TICK_HZ;
  localparam int PW   = (PDIV > 1) ? $clog2(PDIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PDIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [W-1:0] maxValue();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < ND; i++) begin
      v[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
    end
    return v;
  endfunction

  localparam logic [W-1:0] MAX_VAL = maxValue();

  // Ripple a +1/-1 through digits lo..hi only; digits outside the range never see the carry.
  function automatic logic [W-1:0] bcdStep(input logic [W-1:0] v, input logic up,
                                           input int lo, input int hi);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    logic [3:0]   lim;
    r = v;
    c = 1'b1;
    for (int i = 0; i < ND; i++) begin
      lim = (i == 1) ? 4'd5 : 4'd9;
      d   = v[4*i +: 4];
      if (c && (i >= lo) && (i <= hi)) begin
        if (up) begin
          if (d >= lim) begin
            d = 4'd0;
          end else begin
            d = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            d = lim;
          end else begin
            d = d - 4'd1;
            c = 1'b0;
          end
        end
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    time_q, time_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            mode_q, mode_d;
  logic            paused_q, paused_d;
  logic            tick_q, tick_d;
  logic            running_q, alarm_q;
  logic            startBtn_q, secBtn_q, minBtn_q, clrBtn_q;

  logic startEv, clrEv, secEdge, minEdge, secEv, minEv;

  assign startEv = startBtn_q & ~START_STOP_N;
  assign clrEv   = clrBtn_q   & ~CLR_N;
  assign secEdge = secBtn_q   & ~ADD_SEC_N;
  assign minEdge = minBtn_q   & ~ADD_MIN_N;

`ifdef HOLD_REPEAT_EN
  localparam int FIRST = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam int REP   = (CLK_HZ / 8 > 0) ? CLK_HZ / 8 : 1;
  localparam int HW    = $clog2(FIRST + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          addHeld, repeatPulse;

  // After FIRST held cycles fire, then reload so the next pulse comes REP cycles later.
  always_comb begin
    hold_d      = '0;
    repeatPulse = 1'b0;
    addHeld     = (~ADD_SEC_N | ~ADD_MIN_N) && (state_q == IDLE);
    if (addHeld) begin
      if (hold_q == HW'(FIRST - 1)) begin
        repeatPulse = 1'b1;
        hold_d      = HW'(FIRST - REP);
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (!RESET) hold_q <= '0;
    else        hold_q <= hold_d;
  end

  assign secEv = secEdge | (repeatPulse & ~ADD_SEC_N);
  assign minEv = minEdge | (repeatPulse & ~ADD_MIN_N);
`else
  assign secEv = secEdge;
  assign minEv = minEdge;
`endif

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    presc_d  = presc_q;
    mode_d   = mode_q;
    paused_d = paused_q;
    tick_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (startEv) begin
          if (MODE_UP || (time_q != '0)) begin
            state_d  = RUN;
            mode_d   = MODE_UP;
            paused_d = 1'b0;
            // A resumed run keeps its partial period; a fresh start begins a full one.
            if (!paused_q) presc_d = '0;
          end
        end else if (clrEv) begin
          time_d   = '0;
          paused_d = 1'b0;
        end else begin
          if (secEv) time_d = bcdStep(time_d, 1'b1, 0, 1);
          if (minEv) time_d = bcdStep(time_d, 1'b1, 2, ND - 1);
          if (secEv || minEv) paused_d = 1'b0;
        end
      end
      RUN: begin
        if (tick_q && (time_q == (mode_q ? MAX_VAL : '0))) begin
          state_d  = DONE;
          paused_d = 1'b0;
        end else begin
          if (presc_q == PMAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            time_d  = bcdStep(time_q, mode_q, 0, ND - 1);
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (startEv) begin
            state_d  = IDLE;
            paused_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (startEv || clrEv) state_d = IDLE;
        if (clrEv) time_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      time_q     <= '0;
      presc_q    <= '0;
      mode_q     <= 1'b0;
      paused_q   <= 1'b0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      alarm_q    <= 1'b0;
      startBtn_q <= 1'b1;
      secBtn_q   <= 1'b1;
      minBtn_q   <= 1'b1;
      clrBtn_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      presc_q    <= presc_d;
      mode_q     <= mode_d;
      paused_q   <= paused_d;
      tick_q     <= tick_d;
      running_q  <= (state_d == RUN);
      alarm_q    <= (state_d == DONE);
      startBtn_q <= START_STOP_N;
      secBtn_q   <= ADD_SEC_N;
      minBtn_q   <= ADD_MIN_N;
      clrBtn_q   <= CLR_N;
    end
  end

  assign TIME_BCD = time_q;
  assign RUNNING  = running_q;
  assign ALARM    = alarm_q;
  assign TICK     = tick_q;

endmodule

// File: doc/countdown_timer_sync.md
Name: countdown_timer_sync

Overview:
Parametrised, fully synchronous mm:ss timer for the UP2 board. It counts down, or up in stopwatch mode, from a value set with the debounced front-panel buttons. The block generates its own 1 Hz tick from MCLK, so no derived clocks are needed. It drives BCD digits to the existing bcd_to_7seg decoders and raises an alarm at the end of the count.

Parameters:
CLK_HZ, 25175000, MCLK frequency in Hz
TICK_HZ, 1, count rate in Hz; prescaler terminal value = CLK_HZ/TICK_HZ-1
MIN_DIGITS, 2, number of BCD minute digits (1..4); minutes range 0..10^MIN_DIGITS-1

Ports:
MCLK  input  1  system clock; all logic on rising edge
RESET  input  1  synchronous, active-low reset
START_STOP_N  input  1  debounced button, 0 while pressed
ADD_SEC_N  input  1  debounced button, 0 while pressed
ADD_MIN_N  input  1  debounced button, 0 while pressed
CLR_N  input  1  debounced button, 0 while pressed; clears the value
MODE_UP  input  1  0 = count down, 1 = count up; sampled at start
TIME_BCD  output  4*(MIN_DIGITS+2)  packed BCD, MSB = top minute digit; [7:4] = sec tens (0..5), [3:0] = sec units
RUNNING  output  1  high while in RUN
ALARM  output  1  high while in DONE
TICK  output  1  one-cycle pulse on each counted tick, RUN only

Behaviour:
- Reset (RESET=0 at an MCLK edge): state IDLE, TIME_BCD=0, RUNNING=0, ALARM=0, TICK=0, prescaler=0, button edge registers=1. Reset overrides every other input.
- Button event: the button register is 1 in the previous cycle and the input is 0 in the current cycle. There is 1 cycle of latency from press to effect. Holding a button gives exactly one event.
- IDLE:
  - ADD_SEC event: seconds +1, wrapping 59->00 with no carry into minutes.
  - ADD_MIN event: minutes +1, wrapping max->0.
  - ADD_SEC and ADD_MIN events in the same cycle: both apply.
  - CLR event: value=0. If CLR coincides with an add, CLR wins.
  - START event: latch MODE_UP and clear the prescaler.
    - Down mode with value 00:00: start is ignored and the state stays IDLE.
    - Otherwise go to RUN next cycle.
  - START event coincident with add or CLR: start wins, the others are dropped.
- RUN:
  - Prescaler increments every cycle. At terminal value it wraps to 0, asserts TICK for 1 cycle and updates the value in that same cycle.
  - The first tick comes CLK_HZ/TICK_HZ cycles after RUNNING rises.
  - Down mode: BCD decrement with borrow chain (sec units 0->9, sec tens 0->5, minute digits 0->9). If the result is 00:00, go to DONE next cycle.
  - Up mode: BCD increment with carry chain. If the result is max:59, go to DONE.
  - START event: go to IDLE (pause). The value and prescaler are held, and a resumed run continues the partial period.
  - ADD and CLR are ignored.
  - START event on the same cycle as a terminal tick: the tick applies and the state goes to IDLE. DONE is not entered; ALARM stays 0 and the value is final.
- DONE:
  - ALARM=1, value frozen, TICK=0.
  - START or CLR event: go to IDLE. CLR also zeroes the value.
  - ADD events are ignored.
- RUNNING and ALARM are registered outputs decoded from state. They change on the cycle after the transition condition.
- Every BCD digit stays within 0..9, and sec tens within 0..5, in all states.

Optional Feature:
HOLD_REPEAT_EN.
- Defined: in IDLE, holding ADD_SEC_N or ADD_MIN_N low for CLK_HZ/2 cycles after the initial event generates repeat events every CLK_HZ/8 cycles until release. The repeat counter resets on release or state change.
- Undefined: one event per press; the repeat logic is absent.

Test Plan:
- Bench parameters: CLK_HZ=8, TICK_HZ=1, MIN_DIGITS=2.
- Reset: hold RESET=0 with every button pressed -> TIME_BCD=0, RUNNING=0, ALARM=0, TICK=0.
- Set 00:02 (2 ADD_SEC presses), press START, down mode -> RUNNING next cycle; TICK after 8 cycles gives 00:01; at 16 cycles 00:00; ALARM=1 next cycle; START press -> IDLE, ALARM=0.
- Set 01:00, down -> first tick gives 00:59 (borrow across minutes).
- ADD_SEC at 59 -> 00 with minutes unchanged. ADD_MIN at 99 -> 00. ADD_SEC and ADD_MIN in the same cycle from 00:00 -> 01:01.
- Start at 00:00 in down mode -> stays IDLE, RUNNING=0. Up mode from 99:58 -> 99:59 after 8 cycles, then ALARM.
- Pause after 3 cycles of RUN, resume -> next TICK 5 cycles after resume. RESET asserted mid-RUN -> all outputs 0 the next cycle.
